mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
Memory-access pipeline stage directly downstream of the execute stage and upstream of write-back. It latches the 73-bit execute-to-memory bus and completes loads by sampling data-RAM read data, whose address was issued from the execute stage. It selects the final register-file write data and drives the standard valid/allow_in handshake. It also publishes stall (ST) and bypass (BY) buses and holds load data stable across write-back back-pressure.

Parameters:
LOAD_LAT, 1, MEM-stage cycle (1 = first cycle after entry) in which data_ram_r_data is valid for a load; legal 1..7.
CNT_W, 3, width of the load wait counter; must satisfy 2^CNT_W > LOAD_LAT.

Ports:
clk  in  1  clock; all state updates on rising edge.
reset  in  1  asynchronous, active-low reset (asserted when 0).
EXE_to_MEM_bus  in  73  {sel_rf_w_data[72:71], sel_rf_w_en[70], sel_MEM_gene[69], PC_plus_4[68:37], alu_res[36:5], RegFile_target_w_addr[4:0]}.
EXE_to_MEM_valid  in  1  upstream holds a valid instruction.
MEM_allow_in  out  1  stage can accept this cycle.
data_ram_r_data  in  32  data RAM read port.
WB_allow_in  in  1  write-back can accept.
MEM_to_WB_valid  out  1  instruction complete and valid toward WB.
MEM_to_WB_bus  out  70  {sel_rf_w_en[69], PC_plus_4[68:37], RegFile_w_data[36:5], RegFile_target_w_addr[4:0]}.
MEM_to_ST_bus  out  7  {MEM_valid[6], load_pending[5], RegFile_target_w_addr[4:0]}.
MEM_to_BY_bus  out  39  {sel_rf_w_en[38], by_valid[37], RegFile_target_w_addr[36:32], RegFile_w_data[31:0]}.

Behaviour:
- Reset (reset==0, asynchronous): MEM_valid=0, wait counter=0, ld_captured=0, load buffer=0, input register=0. Resulting outputs: MEM_to_WB_valid=0, MEM_allow_in=1, ST bit6=0, BY bit37=0, all bus data fields 0.
- Handshake:
  - MEM_allow_in = ~MEM_valid | (MEM_ready_go & WB_allow_in).
  - MEM_to_WB_valid = MEM_valid & MEM_ready_go.
  - When MEM_allow_in=1, MEM_valid <= EXE_to_MEM_valid; otherwise MEM_valid holds.
  - Input register loads EXE_to_MEM_bus only when MEM_allow_in & EXE_to_MEM_valid; otherwise it holds.
- Load detection: is_load = sel_MEM_gene. Non-loads give MEM_ready_go=1 in the entry cycle, so latency through the stage is one cycle.
- Load wait counter:
  - On accept (MEM_allow_in & EXE_to_MEM_valid), cnt <= 1 and ld_captured <= 0.
  - Otherwise, while MEM_valid & is_load & cnt<LOAD_LAT, cnt increments.
  - cnt saturates at LOAD_LAT.
  - cnt==LOAD_LAT & ~ld_captured is the capture cycle: load buffer <= data_ram_r_data and ld_captured <= 1.
- MEM_ready_go = ~is_load | ld_captured | (cnt==LOAD_LAT).
- load_data = ld_captured ? load buffer : data_ram_r_data. Data stays stable while WB stalls even if the RAM output changes.
- RegFile_w_data by sel_rf_w_data:
  - 00: alu_res.
  - 01: PC_plus_4+4, modulo 2^32 (wraps at 0xFFFFFFFC -> 0x00000000).
  - 10: load_data.
  - 11: 0.
- load_pending = MEM_valid & is_load & ~MEM_ready_go. The ID stage uses it to stall a dependent instruction.
- by_valid = MEM_valid & MEM_ready_go. Bypass data is never offered before load data is valid.
- Simultaneous leave/enter: when MEM_ready_go & WB_allow_in & EXE_to_MEM_valid in the same cycle, the new instruction is captured and the counter restarts with no bubble.
- WB stall with a completed load: the stage holds everything and cnt stays saturated.
- Reset mid-load clears all state immediately. The in-flight load is discarded with no WB or BY assertion.
- Empty stage (MEM_valid=0): bus data fields still reflect the register contents, but every valid qualifier is 0.

Test Plan:
1. ALU op: accept bus with sel_rf_w_data=00, alu_res=0x1234_5678, addr=5, WB_allow_in=1 -> next cycle MEM_to_WB_valid=1, RegFile_w_data=0x12345678, BY={1,1,5,0x12345678}.
2. Load, LOAD_LAT=2: accept load addr=7, RAM returns 0xDEADBEEF in cycle 2 -> cycle 1: load_pending=1, MEM_allow_in=0, by_valid=0; cycle 2: MEM_to_WB_valid=1, RegFile_w_data=0xDEADBEEF.
3. WB back-pressure: LOAD_LAT=1 load captured, WB_allow_in=0 for 3 cycles, RAM output changes to 0 -> RegFile_w_data stays 0xDEADBEEF, MEM_allow_in=0 throughout; releases the cycle WB_allow_in=1.
4. Link/wrap: sel_rf_w_data=01, PC_plus_4=0xFFFFFFFC -> RegFile_w_data=0x00000000; PC_plus_4=0xBFC00004 -> 0xBFC00008.
5. Back-to-back: valid instructions every cycle with WB_allow_in=1, the second being a LOAD_LAT=1 load -> no bubbles, MEM_to_WB_valid continuously 1.
6. Async reset: assert reset=0 mid-cycle during a pending load -> MEM_to_WB_valid, ST bit6 and BY bit37 drop immediately; MEM_allow_in=1; after release, no stale write appears.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between execute and write-back.
// Latches the EXE->MEM bus, completes loads, picks the register write data.
//
// Ports:
//   clk               rising-edge clock
//   reset             asynchronous active-low reset
//   EXE_to_MEM_bus    73b {sel_rf_w_data, sel_rf_w_en, sel_MEM_gene,
//                          PC_plus_4, alu_res, RegFile_target_w_addr}
//   EXE_to_MEM_valid  upstream instruction valid
//   MEM_allow_in      stage can accept this cycle
//   data_ram_r_data   data RAM read data (address issued from EXE)
//   WB_allow_in       write-back can accept
//   MEM_to_WB_valid   completed instruction offered to WB
//   MEM_to_WB_bus     70b {sel_rf_w_en, PC_plus_4, RegFile_w_data, w_addr}
//   MEM_to_ST_bus     7b  {MEM_valid, load_pending, w_addr}
//   MEM_to_BY_bus     39b {sel_rf_w_en, by_valid, w_addr, RegFile_w_data}
module mem_stage #(
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [72:0] EXE_to_MEM_bus,
    input  logic        EXE_to_MEM_valid,
    output logic        MEM_allow_in,
    input  logic [31:0] data_ram_r_data,
    input  logic        WB_allow_in,
    output logic        MEM_to_WB_valid,
    output logic [69:0] MEM_to_WB_bus,
    output logic [6:0]  MEM_to_ST_bus,
    output logic [38:0] MEM_to_BY_bus
);

    typedef struct packed {
        logic [1:0]  sel_rf_w_data;
        logic        sel_rf_w_en;
        logic        sel_mem_gene;
        logic [31:0] pc_plus_4;
        logic [31:0] alu_res;
        logic [4:0]  w_addr;
    } exe_mem_t;

    localparam logic [CNT_W-1:0] LAT = CNT_W'(LOAD_LAT);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    exe_mem_t         in_q;
    logic             mem_valid;
    logic [CNT_W-1:0] cnt;
    logic             ld_captured;
    logic [31:0]      ld_buf;

    logic             is_load;
    logic             cnt_done;
    logic             ready_go;
    logic             accept;
    logic             capture;
    logic             load_pending;
    logic             by_valid;
    logic [31:0]      load_data;
    logic [31:0]      link_addr;
    logic [31:0]      rf_w_data;

    assign is_load  = in_q.sel_mem_gene;
    assign cnt_done = (cnt == LAT);

    // ld_captured keeps a finished load ready even though cnt
    // alone would also hold it ready while saturated.
    assign ready_go = ~is_load | ld_captured | cnt_done;

    assign MEM_allow_in    = ~mem_valid | (ready_go & WB_allow_in);
    assign MEM_to_WB_valid = mem_valid & ready_go;
    assign accept          = MEM_allow_in & EXE_to_MEM_valid;

    // The first cycle the RAM data is valid is the only one we sample;
    // afterwards the buffer shields WB from a changing RAM output.
    assign capture = ~accept & cnt_done & ~ld_captured;

    assign load_pending = mem_valid & is_load & ~ready_go;
    assign by_valid     = mem_valid & ready_go;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_valid <= 1'b0;
        end else if (MEM_allow_in) begin
            mem_valid <= EXE_to_MEM_valid;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_q <= '0;
        end else if (accept) begin
            in_q <= EXE_to_MEM_bus;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= ONE;
        end else if (mem_valid && is_load && (cnt < LAT)) begin
            cnt <= cnt + ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ld_captured <= 1'b0;
            ld_buf      <= '0;
        end else if (accept) begin
            ld_captured <= 1'b0;
        end else if (capture) begin
            ld_captured <= 1'b1;
            ld_buf      <= data_ram_r_data;
        end
    end

    assign load_data = ld_captured ? ld_buf : data_ram_r_data;
    assign link_addr = in_q.pc_plus_4 + 32'd4;

    always_comb begin
        rf_w_data = '0;
        unique case (in_q.sel_rf_w_data)
            2'b00: rf_w_data = in_q.alu_res;
            2'b01: rf_w_data = link_addr;
            2'b10: rf_w_data = load_data;
            2'b11: rf_w_data = '0;
        endcase
    end

    assign MEM_to_WB_bus = {
        in_q.sel_rf_w_en,
        in_q.pc_plus_4,
        rf_w_data,
        in_q.w_addr
    };

    assign MEM_to_ST_bus = {
        mem_valid,
        load_pending,
        in_q.w_addr
    };

    assign MEM_to_BY_bus = {
        in_q.sel_rf_w_en,
        by_valid,
        in_q.w_addr,
        rf_w_data
    };

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: self-checking bench for mem_stage.
// Two instances: u_dut with LOAD_LAT=1, u_dut2 with LOAD_LAT=2.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [72:0] bus;
    logic        exv;
    logic [31:0] ram;
    logic        wba;

    logic        a_allow, a_wbv;
    logic [69:0] a_wbbus;
    logic [6:0]  a_st;
    logic [38:0] a_by;

    logic        b_allow, b_wbv;
    logic [69:0] b_wbbus;
    logic [6:0]  b_st;
    logic [38:0] b_by;

    int tests = 0;
    int fails = 0;

    logic [69:0] sbq[$];

    always #5 clk = ~clk;

    mem_stage #(.LOAD_LAT(1), .CNT_W(3)) u_dut (
        .clk(clk), .reset(reset),
        .EXE_to_MEM_bus(bus), .EXE_to_MEM_valid(exv),
        .MEM_allow_in(a_allow), .data_ram_r_data(ram),
        .WB_allow_in(wba), .MEM_to_WB_valid(a_wbv),
        .MEM_to_WB_bus(a_wbbus), .MEM_to_ST_bus(a_st),
        .MEM_to_BY_bus(a_by)
    );

    mem_stage #(.LOAD_LAT(2), .CNT_W(3)) u_dut2 (
        .clk(clk), .reset(reset),
        .EXE_to_MEM_bus(bus), .EXE_to_MEM_valid(exv),
        .MEM_allow_in(b_allow), .data_ram_r_data(ram),
        .WB_allow_in(wba), .MEM_to_WB_valid(b_wbv),
        .MEM_to_WB_bus(b_wbbus), .MEM_to_ST_bus(b_st),
        .MEM_to_BY_bus(b_by)
    );

    typedef struct {
        logic [1:0]  sel;
        logic        en;
        logic        gene;
        logic [31:0] pc;
        logic [31:0] alu;
        logic [4:0]  addr;
        logic [31:0] ram;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[6];

    function automatic logic [72:0] mk_bus(
        input logic [1:0] sel, input logic en, input logic gene,
        input logic [31:0] pc, input logic [31:0] alu,
        input logic [4:0] addr);
        return {sel, en, gene, pc, alu, addr};
    endfunction

    function automatic logic [69:0] mk_wb(
        input logic en, input logic [31:0] pc,
        input logic [31:0] data, input logic [4:0] addr);
        return {en, pc, data, addr};
    endfunction

    task automatic chk(input string nm, input logic [69:0] act,
                       input logic [69:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every WB transfer of u_dut pops one expected record.
    always @(negedge clk) begin
        if (reset === 1'b1 && a_wbv === 1'b1 && wba === 1'b1) begin
            tests++;
            if (sbq.size() == 0) begin
                fails++;
                $display("FAIL wb_unexpected: got %h expected none", a_wbbus);
            end else begin
                logic [69:0] e;
                e = sbq.pop_front();
                if (a_wbbus !== e) begin
                    fails++;
                    $display("FAIL wb_bus: got %h expected %h", a_wbbus, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{2'b00, 1'b1, 1'b0, 32'h0000_0100, 32'h1234_5678,
                    5'd5, 32'hAAAA_5555, 32'h1234_5678};
        vecs[1] = '{2'b01, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0000_0001,
                    5'd6, 32'h0, 32'h0000_0000};
        vecs[2] = '{2'b01, 1'b1, 1'b0, 32'hBFC0_0004, 32'h0000_0002,
                    5'd7, 32'h0, 32'hBFC0_0008};
        vecs[3] = '{2'b10, 1'b1, 1'b1, 32'h0000_0200, 32'h8000_0000,
                    5'd8, 32'hCAFE_F00D, 32'hCAFE_F00D};
        vecs[4] = '{2'b11, 1'b0, 1'b0, 32'h0000_0300, 32'hFFFF_FFFF,
                    5'd9, 32'h1, 32'h0000_0000};
        vecs[5] = '{2'b00, 1'b1, 1'b0, 32'h0000_0400, 32'hFFFF_FFFF,
                    5'd31, 32'h0, 32'hFFFF_FFFF};

        reset = 1'b0;
        bus   = '0;
        exv   = 1'b0;
        ram   = '0;
        wba   = 1'b1;
        cyc();
        cyc();
        #1;
        chk("rst_wbv", a_wbv, 1'b0);
        chk("rst_allow", a_allow, 1'b1);
        chk("rst_st", a_st, 7'h0);
        chk("rst_by", a_by, 39'h0);
        chk("rst_wbbus", a_wbbus, 70'h0);
        reset = 1'b1;

        // Single instructions, one at a time
        for (int i = 0; i < 6; i++) begin
            cyc();
            bus = mk_bus(vecs[i].sel, vecs[i].en, vecs[i].gene,
                         vecs[i].pc, vecs[i].alu, vecs[i].addr);
            exv = 1'b1;
            wba = 1'b1;
            ram = vecs[i].ram;
            sbq.push_back(mk_wb(vecs[i].en, vecs[i].pc,
                                vecs[i].exp, vecs[i].addr));
            #1;
            chk("vec_allow_empty", a_allow, 1'b1);
            cyc();
            exv = 1'b0;
            #1;
            chk("vec_wbv", a_wbv, 1'b1);
            chk("vec_by", a_by,
                {vecs[i].en, 1'b1, vecs[i].addr, vecs[i].exp});
            chk("vec_st", a_st, {1'b1, 1'b0, vecs[i].addr});
            cyc();
            #1;
            chk("vec_left", a_wbv, 1'b0);
        end

        // LOAD_LAT=2 load on u_dut2; u_dut completes it in cycle 1
        cyc();
        reset = 1'b0;
        #2;
        reset = 1'b1;
        bus = mk_bus(2'b10, 1'b1, 1'b1, 32'h0000_1000, 32'h40, 5'd7);
        exv = 1'b1;
        wba = 1'b1;
        ram = 32'h1111_1111;
        sbq.push_back(mk_wb(1'b1, 32'h0000_1000, 32'h1111_1111, 5'd7));
        #1;
        chk("lat2_allow_empty", b_allow, 1'b1);
        cyc();
        exv = 1'b0;
        #1;
        chk("lat2_c1_pending", b_st[5], 1'b1);
        chk("lat2_c1_allow", b_allow, 1'b0);
        chk("lat2_c1_byv", b_by[37], 1'b0);
        chk("lat2_c1_wbv", b_wbv, 1'b0);
        cyc();
        ram = 32'hDEAD_BEEF;
        #1;
        chk("lat2_c2_wbv", b_wbv, 1'b1);
        chk("lat2_c2_data", b_wbbus[36:5], 32'hDEAD_BEEF);
        chk("lat2_c2_pending", b_st[5], 1'b0);
        chk("lat2_c2_byv", b_by[37], 1'b1);
        cyc();
        #1;
        chk("lat2_left", b_wbv, 1'b0);

        // WB back-pressure with a captured load
        cyc();
        bus = mk_bus(2'b10, 1'b1, 1'b1, 32'h0000_2000, 32'h80, 5'd3);
        exv = 1'b1;
        wba = 1'b1;
        ram = 32'hDEAD_BEEF;
        sbq.push_back(mk_wb(1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 5'd3));
        cyc();
        exv = 1'b0;
        wba = 1'b0;
        #1;
        chk("bp_c1_data", a_wbbus[36:5], 32'hDEAD_BEEF);
        chk("bp_c1_allow", a_allow, 1'b0);
        for (int k = 0; k < 2; k++) begin
            cyc();
            ram = 32'h0;
            #1;
            chk("bp_hold_wbv", a_wbv, 1'b1);
            chk("bp_hold_data", a_wbbus[36:5], 32'hDEAD_BEEF);
            chk("bp_hold_allow", a_allow, 1'b0);
        end
        cyc();
        wba = 1'b1;
        #1;
        chk("bp_rel_allow", a_allow, 1'b1);
        chk("bp_rel_data", a_wbbus[36:5], 32'hDEAD_BEEF);
        cyc();
        #1;
        chk("bp_left", a_wbv, 1'b0);

        // Back-to-back stream, second is a load
        ram = 32'h0BAD_F00D;
        for (int i = 0; i < 4; i++) begin
            logic [1:0]  s;
            logic        g;
            logic [31:0] pc;
            logic [31:0] d;
            pc = 32'h0000_3000 + 32'(i) * 32'd4;
            s  = (i == 1) ? 2'b10 : ((i == 2) ? 2'b01 : 2'b00);
            g  = (i == 1);
            d  = (i == 1) ? 32'h0BAD_F00D :
                 ((i == 2) ? pc + 32'd4 : 32'h5000 + 32'(i));
            if (i != 0) cyc();
            bus = mk_bus(s, 1'b1, g, pc, 32'h5000 + 32'(i), 5'(10 + i));
            exv = 1'b1;
            wba = 1'b1;
            sbq.push_back(mk_wb(1'b1, pc, d, 5'(10 + i)));
            #1;
            chk("b2b_allow", a_allow, 1'b1);
            if (i != 0) chk("b2b_wbv", a_wbv, 1'b1);
        end
        cyc();
        exv = 1'b0;
        #1;
        chk("b2b_last_wbv", a_wbv, 1'b1);
        cyc();
        #1;
        chk("b2b_left", a_wbv, 1'b0);

        // Async reset during a pending load
        cyc();
        bus = mk_bus(2'b10, 1'b1, 1'b1, 32'h0000_4000, 32'hC0, 5'd12);
        exv = 1'b1;
        wba = 1'b1;
        ram = 32'h5555_5555;
        cyc();
        exv = 1'b0;
        #1;
        chk("ar_pre_pending", b_st[6:5], 2'b11);
        reset = 1'b0;
        #1;
        chk("ar_a_wbv", a_wbv, 1'b0);
        chk("ar_a_st6", a_st[6], 1'b0);
        chk("ar_a_by37", a_by[37], 1'b0);
        chk("ar_a_allow", a_allow, 1'b1);
        chk("ar_a_wbbus", a_wbbus, 70'h0);
        chk("ar_b_st6", b_st[6], 1'b0);
        chk("ar_b_by37", b_by[37], 1'b0);
        chk("ar_b_allow", b_allow, 1'b1);
        cyc();
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("ar_no_stale_a", a_wbv, 1'b0);
            chk("ar_no_stale_b", {b_wbv, b_by[37]}, 2'b00);
        end

        cyc();
        chk("sb_drained", 70'(sbq.size()), 70'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
